// File: rtl/psum_accum_buffer.sv
// Running-sum register bank for systolic partial-sum tiles.
// Accumulates num_tiles tiles lane by lane, then holds the result on a
// valid/ready output until the downstream stage takes it.

// One accumulator lane: loads a sign-extended first tile, then adds each later tile.
module psum_accum_lane #(
  parameter int ACC_WIDTH    = 18,
  parameter int ACTUAL_WIDTH = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    add,
  input  logic [ACC_WIDTH-1:0]    psum,
  output logic [ACTUAL_WIDTH-1:0] acc
);
  logic [ACTUAL_WIDTH-1:0] psum_sext;

  assign psum_sext = {{(ACTUAL_WIDTH-ACC_WIDTH){psum[ACC_WIDTH-1]}}, psum};

  // Lane register: clear wins, then first-tile load, then running add (wraps).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (load)  acc <= psum_sext;
    else if (add)   acc <= acc + psum_sext;
  end
endmodule

module psum_accum_buffer #(
  parameter int ACC_WIDTH       = 18,
  parameter int ACTUAL_WIDTH    = 21,
  parameter int SYSTOLIC_COLUMN = 16,
  parameter int PE_BLK_COUNT    = 16,
  parameter int MAX_TILES       = 16,
  parameter int CW              = $clog2(MAX_TILES+1),
  parameter int NL              = PE_BLK_COUNT*SYSTOLIC_COLUMN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [CW-1:0]              cfg_num_tiles,
  input  logic                       psum_valid,
  output logic                       psum_ready,
  input  logic [NL*ACC_WIDTH-1:0]    psum_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NL*ACTUAL_WIDTH-1:0] out_data,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tile_cnt, num_tiles_q, ntiles_eff;
  logic          accept, load_first, add_tile, last_tile, out_done;

  // Handshakes; clear swallows any transfer presented in the same cycle.
  assign psum_ready = (state_q != DRAIN);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign accept     = psum_valid & psum_ready & ~clear;
  assign load_first = accept & (state_q == IDLE);
  assign add_tile   = accept & (state_q == ACCUM);
  assign out_done   = out_valid & out_ready & ~clear;
  assign last_tile  = (tile_cnt == num_tiles_q - CW'(1));

  // Tile count from config: 0 means a single tile, oversize clamps to MAX_TILES.
  always_comb begin
    ntiles_eff = cfg_num_tiles;
    if (cfg_num_tiles == '0)                  ntiles_eff = CW'(1);
    else if (cfg_num_tiles > CW'(MAX_TILES))  ntiles_eff = CW'(MAX_TILES);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_first) state_d = (ntiles_eff == CW'(1)) ? DRAIN : ACCUM;
      ACCUM:   if (add_tile && last_tile) state_d = DRAIN;
      DRAIN:   if (out_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Tile counter and latched tile target (config sampled only on first tile).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_cnt    <= '0;
      num_tiles_q <= '0;
    end else if (clear) begin
      tile_cnt    <= '0;
    end else if (load_first) begin
      num_tiles_q <= ntiles_eff;
      tile_cnt    <= CW'(1);
    end else if (add_tile) begin
      tile_cnt    <= tile_cnt + CW'(1);
    end else if (out_done) begin
      tile_cnt    <= '0;
    end
  end

  // Lane array; each lane's acc register drives its out_data slice directly.
  for (genvar n = 0; n < NL; n++) begin : g_lane
    psum_accum_lane #(
      .ACC_WIDTH    (ACC_WIDTH),
      .ACTUAL_WIDTH (ACTUAL_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .load  (load_first),
      .add   (add_tile),
      .psum  (psum_data[ACC_WIDTH*(n+1)-1 -: ACC_WIDTH]),
      .acc   (out_data[ACTUAL_WIDTH*(n+1)-1 -: ACTUAL_WIDTH])
    );
  end
endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboarded bench for psum_accum_buffer: expected sums are modelled per lane
// as tiles are driven, queued, and compared when the result is presented.
module tb_psum_accum_buffer;
  localparam int AW = 18;
  localparam int OW = 21;
  localparam int NL = 256;
  localparam int CW = 5;

  logic                 clk = 0;
  logic                 rst = 1;
  logic                 clear = 0;
  logic [CW-1:0]        cfg_num_tiles = '0;
  logic                 psum_valid = 0;
  logic                 psum_ready;
  logic [NL*AW-1:0]     psum_data = '0;
  logic                 out_valid;
  logic                 out_ready = 0;
  logic [NL*OW-1:0]     out_data;
  logic                 busy;

  psum_accum_buffer dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_num_tiles(cfg_num_tiles),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_data(psum_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0]    tile_v [NL];
  logic [OW-1:0]    macc   [NL];
  logic [NL*OW-1:0] exp_q  [$];

  function automatic logic [OW-1:0] sext(input logic [AW-1:0] t);
    return {{(OW-AW){t[AW-1]}}, t};
  endfunction

  function automatic logic [NL*AW-1:0] pack_tile();
    logic [NL*AW-1:0] p;
    for (int n = 0; n < NL; n++) p[AW*n +: AW] = tile_v[n];
    return p;
  endfunction

  function automatic logic [NL*OW-1:0] pack_acc();
    logic [NL*OW-1:0] p;
    for (int n = 0; n < NL; n++) p[OW*n +: OW] = macc[n];
    return p;
  endfunction

  task automatic fill_tile(input logic [AW-1:0] v);
    for (int n = 0; n < NL; n++) tile_v[n] = v;
  endtask

  task automatic model_clear();
    for (int n = 0; n < NL; n++) macc[n] = '0;
  endtask

  // Drive tile_v for one handshake (called at negedge); update model.
  task automatic send_tile(input bit first);
    int waits = 0;
    psum_data  = pack_tile();
    psum_valid = 1;
    while (psum_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    vectors++;
    if (psum_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_tile_timeout: psum_ready=%b required 1", psum_ready);
    end
    @(posedge clk);
    @(negedge clk);
    psum_valid = 0;
    for (int n = 0; n < NL; n++) macc[n] = first ? sext(tile_v[n]) : macc[n] + sext(tile_v[n]);
  endtask

  // Compare the presented result with the scoreboard head, then accept it.
  task automatic take_result(input string name);
    logic [NL*OW-1:0] e;
    int bad;
    e = exp_q.pop_front();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_out_valid: got %b required 1", name, out_valid);
    end
    vectors++;
    if (out_data !== e) begin
      bad = 0;
      for (int n = NL-1; n >= 0; n--) if (out_data[OW*n +: OW] !== e[OW*n +: OW]) bad = n;
      miscompares++;
      $display("FAIL %s_data lane %0d: got %h required %h", name, bad,
               out_data[OW*bad +: OW], e[OW*bad +: OW]);
    end
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_release: out_valid=%b busy=%b required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (psum_ready !== 1 || out_valid !== 0 || out_data !== '0 || busy !== 0) begin
      miscompares++;
      $display("FAIL reset_initial: rdy=%b ov=%b busy=%b data_nz=%b", psum_ready, out_valid, busy, |out_data);
    end
    @(negedge clk); rst = 0;
    // Two tiles into a 4-tile run, then reset mid-accumulation.
    cfg_num_tiles = 4;
    fill_tile(18'd55); send_tile(1); send_tile(0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_busy: got %b required 1", busy);
    end
    rst = 1;
    #1;
    vectors++;
    if (psum_ready !== 1 || out_valid !== 0 || out_data !== '0 || busy !== 0) begin
      miscompares++;
      $display("FAIL reset_during: rdy=%b ov=%b busy=%b data_nz=%b", psum_ready, out_valid, busy, |out_data);
    end
    @(negedge clk); rst = 0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (psum_ready !== 1 || out_valid !== 0 || out_data !== '0 || busy !== 0) begin
      miscompares++;
      $display("FAIL reset_after: rdy=%b ov=%b busy=%b data_nz=%b", psum_ready, out_valid, busy, |out_data);
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] vals [4];
    vals = '{18'd100, 18'd200, -18'sd50, 18'd7};
    cfg_num_tiles = 4;
    for (int t = 0; t < 4; t++) begin
      fill_tile(vals[t]);
      send_tile(t == 0);
    end
    exp_q.push_back(pack_acc());
    vectors++;
    if (out_data[OW*37 +: OW] !== 21'd257) begin
      miscompares++;
      $display("FAIL basic_lane37: got %0d required 257", out_data[OW*37 +: OW]);
    end
    take_result("basic");
  endtask

  task automatic test_wrap();
    cfg_num_tiles = 16;
    fill_tile(18'h1FFFF);
    tile_v[0] = 18'h20000;
    for (int t = 0; t < 16; t++) send_tile(t == 0);
    exp_q.push_back(pack_acc());
    vectors++;
    if (out_data[OW*1 +: OW] !== 21'h1FFFF0 || out_data[0 +: OW] !== 21'h000000) begin
      miscompares++;
      $display("FAIL wrap_lanes: lane1=%h required 1ffff0, lane0=%h required 000000",
               out_data[OW*1 +: OW], out_data[0 +: OW]);
    end
    take_result("wrap");
  endtask

  task automatic test_backpressure();
    logic [NL*OW-1:0] hold;
    cfg_num_tiles = 3;
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < NL; n++) tile_v[n] = AW'($urandom);
      send_tile(t == 0);
    end
    hold = pack_acc();
    exp_q.push_back(hold);
    fill_tile(18'd999);
    psum_data  = pack_tile();
    psum_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (psum_ready !== 0 || out_valid !== 1 || out_data !== hold) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: rdy=%b ov=%b data_match=%b", c, psum_ready, out_valid, out_data === hold);
      end
    end
    psum_valid = 0;
    take_result("backpressure");
  endtask

  task automatic test_edge();
    // cfg=0 and cfg=1 both complete on one tile.
    for (int k = 0; k < 2; k++) begin
      cfg_num_tiles = CW'(k);
      fill_tile(k == 0 ? -18'sd1234 : 18'd4321);
      send_tile(1);
      exp_q.push_back(pack_acc());
      take_result(k == 0 ? "cfg0" : "cfg1");
    end
    // cfg=20 clamps to 16; a mid-run config change must be ignored.
    cfg_num_tiles = 20;
    for (int t = 0; t < 15; t++) begin
      fill_tile(AW'(t + 1));
      send_tile(t == 0);
      cfg_num_tiles = 1;
    end
    vectors++;
    if (out_valid !== 1'b0 || psum_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clamp_early: after 15 tiles ov=%b rdy=%b required 0 1", out_valid, psum_ready);
    end
    fill_tile(18'd16);
    send_tile(0);
    exp_q.push_back(pack_acc());
    take_result("clamp20");
  endtask

  task automatic test_clear();
    cfg_num_tiles = 4;
    fill_tile(18'd50);
    send_tile(1); send_tile(0);
    fill_tile(18'd99);
    psum_data  = pack_tile();
    psum_valid = 1;
    clear = 1;
    @(posedge clk);
    @(negedge clk);
    clear = 0;
    psum_valid = 0;
    model_clear();
    vectors++;
    if (busy !== 0 || out_valid !== 0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL clear_state: busy=%b ov=%b data_nz=%b required 0 0 0", busy, out_valid, |out_data);
    end
    fill_tile(18'd3);
    for (int t = 0; t < 4; t++) send_tile(t == 0);
    exp_q.push_back(pack_acc());
    vectors++;
    if (out_data[OW*255 +: OW] !== 21'd12) begin
      miscompares++;
      $display("FAIL clear_fresh_lane255: got %0d required 12", out_data[OW*255 +: OW]);
    end
    take_result("clear_fresh");
  endtask

  task automatic test_back_to_back();
    cfg_num_tiles = 2;
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 2; t++) begin
        for (int n = 0; n < NL; n++) tile_v[n] = AW'($urandom);
        send_tile(t == 0);
      end
      exp_q.push_back(pack_acc());
      take_result(r == 0 ? "b2b_0" : "b2b_1");
    end
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge();
    test_clear();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
